store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending-store entries (power of two, 2..16).
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and reset (in, 1), with reset synchronous and active-high; one clock domain only.
REQ-003 SHALL have core store-side ports: st_valid (in, 1, store request); st_ready (out, 1, store accepted); st_addr (in, 32, byte address); st_wdata (in, 32, store data); st_size (in, 2, 00 byte, 01 half, 10 word); st_misaligned (out, 1, store rejected as misaligned).
REQ-004 SHALL have core load-side ports: ld_valid (in, 1, load request); ld_addr (in, 32, load address); ld_size (in, 2, load size); ld_signed (in, 1, sign-extend load); ld_stall (out, 1, load must hold).
REQ-005 SHALL have control ports: flush (in, 1, drain request for fence); drained (out, 1, buffer empty); count (out, $clog2(DEPTH+1), occupancy).
REQ-006 SHALL have data-memory-side outputs: mem_addr (32), mem_wdata (32), mem_size (2), mem_signed (1), mem_memread (1), mem_memwrite (1).

Function
REQ-007 SHALL detect misalignment combinationally: half with st_addr[0]=1, or word with st_addr[1:0]!=00.
REQ-008 SHALL raise st_misaligned for a misaligned request while st_valid is high, and SHALL NOT enqueue that request.
REQ-009 SHALL set st_ready = !flush && (count < DEPTH); a store is accepted when st_valid && st_ready && !st_misaligned.
REQ-010 SHALL write an accepted store into the tail entry at the rising edge; the entry is eligible for draining from the next cycle.
REQ-011 SHALL set ld_stall = ld_valid && (some valid entry has addr[31:2] == ld_addr[31:2]); this is a word-granular hazard check.
REQ-012 SHALL treat load_issue = ld_valid && !ld_stall as having port priority: mem_memread=1; mem_addr/mem_size/mem_signed driven from ld_*; mem_memwrite=0.
REQ-013 SHALL drain when !load_issue && count>0: drive mem_addr/mem_wdata/mem_size from the head entry, set mem_memwrite=1 and mem_signed=0, and pop the head at the rising edge.
REQ-014 SHALL keep draining while a load is stalled, so a stalled load is guaranteed to resolve within count cycles.
REQ-015 SHALL drain entries strictly in FIFO order, one per cycle at most.
REQ-016 SHALL leave count unchanged on a simultaneous accept and drain; an accept while full is impossible because st_ready=0.
REQ-017 SHALL wrap head and tail pointers modulo DEPTH.
REQ-018 SHALL set drained = (count==0) combinationally; flush only blocks new accepts and draining proceeds normally.
REQ-019 SHALL drive all mem_* outputs to 0 when idle (no load_issue, no drain).

Reset
REQ-020 SHALL clear head, tail, count and all entry valid bits on reset; pending stores are discarded, including on reset mid-drain.
REQ-021 SHALL hold these output values during and after reset: st_ready=1 (if flush=0), drained=1, count=0, mem_memwrite=0.

Configuration
REQ-022 SHALL provide macro STORE_BUFFER_BYPASS_EN with the following behaviour when defined: if count==0, !load_issue and the store is accepted, the store is driven to memory the same cycle (mem_memwrite=1) and is not enqueued.
REQ-023 SHALL, when STORE_BUFFER_BYPASS_EN is undefined, always enqueue accepted stores, giving a minimum accept-to-memwrite latency of 1 cycle.

Structure
REQ-024 SHALL place the mem_size_e enum (BYTE=00, HALF=01, WORD=10) and the sb_entry_t struct (addr, wdata, size) in shared package mem_pkg.
REQ-025 SHALL implement storage and pointers in one sub-module, sb_fifo (push/pop/head/count, plus word-match search port); arbitration and misalignment checks stay in store_buffer.

Verification
REQ-026 SHALL cover: store word 0x100 data 0xDEADBEEF, no loads -> memwrite with mem_addr=0x100 next cycle (same cycle if bypass), count returns to 0.
REQ-027 SHALL cover: 4 stores with ld_valid held high to non-matching addr 0x200 -> count=4, st_ready=0 for a 5th store, no memwrite until ld_valid drops, then 4 writes in order.
REQ-028 SHALL cover: store byte to 0x103, then load word 0x100 the next cycle -> ld_stall=1 until the entry drains, then memread with mem_addr=0x100.
REQ-029 SHALL cover: half store to 0x101 -> st_misaligned=1, count unchanged, no memwrite.
REQ-030 SHALL cover: 3 pending stores, then flush asserted -> st_ready=0, drained=1 after exactly 3 cycles with no loads.
REQ-031 SHALL cover: reset asserted with count=3 -> the next cycle count=0, drained=1, and no further memwrite.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-access types for the store buffer: access size encoding,
// pending-store entry layout and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        mem_size_e   size;
    } sb_entry_t;

    // Halves need an even address, words need a word-aligned address.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Pending-store storage for the store buffer: circular FIFO with per-entry
// valid bits and a word-granular address match across all valid entries.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output sb_entry_t        head_entry,
    output logic [CNT_W-1:0] count,
    input  logic [29:0]      match_word,
    output logic             match
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sb_entry_t        entries_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // Pointers, occupancy and valid bits; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
        end else begin
            if (push) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + PTR_ONE;
            end
            if (pop) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_r[tail_r] <= push_entry;
        end
    end

    // Word-granular hazard search over every valid entry.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (entries_r[i].addr[31:2] == match_word)) begin
                match = 1'b1;
            end else begin
                match = match;
            end
        end
    end

    assign head_entry = entries_r[head_r];
    assign count      = count_r;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between core and data memory: queues aligned stores, gives
// non-hazarding loads port priority and drains stores in FIFO order.
// Optional STORE_BUFFER_BYPASS_EN writes a store straight through when empty.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_wdata,
    input  logic [1:0]                 st_size,
    output logic                       st_misaligned,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    input  logic [1:0]                 ld_size,
    input  logic                       ld_signed,
    output logic                       ld_stall,
    input  logic                       flush,
    output logic                       drained,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [1:0]                 mem_size,
    output logic                       mem_signed,
    output logic                       mem_memread,
    output logic                       mem_memwrite
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic      misaligned_s;
    logic      accept_s;
    logic      load_issue_s;
    logic      drain_s;
    logic      bypass_s;
    logic      push_s;
    logic      match_s;
    sb_entry_t head_s;
    sb_entry_t push_entry_s;

    assign misaligned_s  = is_misaligned(st_addr[1:0], st_size);
    assign st_misaligned = st_valid && misaligned_s;
    assign st_ready      = !flush && (count < FULL_CNT);
    assign accept_s      = st_valid && st_ready && !misaligned_s;

    assign ld_stall      = ld_valid && match_s;
    assign load_issue_s  = ld_valid && !ld_stall;
    // Draining continues under a stalled load so the hazard always clears.
    assign drain_s       = !load_issue_s && (count != '0);
    assign drained       = (count == '0);

`ifdef STORE_BUFFER_BYPASS_EN
    assign bypass_s = accept_s && !load_issue_s && (count == '0);
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s       = accept_s && !bypass_s;
    assign push_entry_s = '{addr: st_addr, wdata: st_wdata, size: mem_size_e'(st_size)};

    sb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (drain_s),
        .head_entry (head_s),
        .count      (count),
        .match_word (ld_addr[31:2]),
        .match      (match_s)
    );

    // Memory port arbitration: load first, then head-of-queue drain, then bypass.
    always_comb begin
        mem_addr     = 32'h0000_0000;
        mem_wdata    = 32'h0000_0000;
        mem_size     = 2'b00;
        mem_signed   = 1'b0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        if (load_issue_s) begin
            mem_addr    = ld_addr;
            mem_size    = ld_size;
            mem_signed  = ld_signed;
            mem_memread = 1'b1;
        end else if (drain_s) begin
            mem_addr     = head_s.addr;
            mem_wdata    = head_s.wdata;
            mem_size     = head_s.size;
            mem_memwrite = 1'b1;
        end else if (bypass_s) begin
            mem_addr     = st_addr;
            mem_wdata    = st_wdata;
            mem_size     = st_size;
            mem_memwrite = 1'b1;
        end else begin
            mem_memwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [1:0]  st_size;
    logic        st_misaligned;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic        ld_stall;
    logic        flush;
    logic        drained;
    logic [2:0]  count;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        mem_memread;
    logic        mem_memwrite;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } ent_t;

    ent_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_size(st_size), .st_misaligned(st_misaligned),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_signed(ld_signed), .ld_stall(ld_stall),
        .flush(flush), .drained(drained), .count(count),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_wdata = 32'h0; st_size = 2'b00;
        ld_valid = 1'b0; ld_addr = 32'h0; ld_size = 2'b00; ld_signed = 1'b0; flush = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1; st_addr = a; st_wdata = d; st_size = s;
    endtask

    // One cycle: inputs are already applied (at negedge); check, clock, update model.
    task automatic step();
        bit mis, rdy, acc, stall, li, drn, byp;
        logic [31:0] ea, ew;
        logic [1:0]  es;
        logic        esg, erd, ewr;
        ent_t        e;
        #1;
        mis = st_valid && ((st_size == 2'b01 && st_addr[0]) ||
                           (st_size == 2'b10 && st_addr[1:0] != 2'b00));
        rdy = !flush && (q.size() < DEPTH);
        acc = st_valid && rdy && !mis;
        stall = 1'b0;
        foreach (q[i]) if (ld_valid && q[i].addr[31:2] == ld_addr[31:2]) stall = 1'b1;
        li  = ld_valid && !stall;
        drn = !li && (q.size() > 0);
        byp = 1'b0;
`ifdef STORE_BUFFER_BYPASS_EN
        byp = acc && !li && (q.size() == 0);
`endif
        ea = 32'h0; ew = 32'h0; es = 2'b00; esg = 1'b0; erd = 1'b0; ewr = 1'b0;
        if (li) begin
            ea = ld_addr; es = ld_size; esg = ld_signed; erd = 1'b1;
        end else if (drn) begin
            ea = q[0].addr; ew = q[0].wdata; es = q[0].size; ewr = 1'b1;
        end else if (byp) begin
            ea = st_addr; ew = st_wdata; es = st_size; ewr = 1'b1;
        end
        chk("st_ready", {31'd0, st_ready}, {31'd0, rdy});
        chk("st_misaligned", {31'd0, st_misaligned}, {31'd0, mis});
        chk("ld_stall", {31'd0, ld_stall}, {31'd0, stall});
        chk("drained", {31'd0, drained}, {31'd0, q.size() == 0});
        chk("count", {29'd0, count}, 32'(q.size()));
        chk("mem_addr", mem_addr, ea);
        if (!li) chk("mem_wdata", mem_wdata, ew);
        chk("mem_size", {30'd0, mem_size}, {30'd0, es});
        chk("mem_signed", {31'd0, mem_signed}, {31'd0, esg});
        chk("mem_memread", {31'd0, mem_memread}, {31'd0, erd});
        chk("mem_memwrite", {31'd0, mem_memwrite}, {31'd0, ewr});
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (drn) e = q.pop_front();
            if (acc && !byp) q.push_back('{addr: st_addr, wdata: st_wdata, size: st_size});
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state while reset is still held
        step();
        idle();
        step();

        // Single word store, no loads
        store(32'h100, 32'hDEAD_BEEF, 2'b10); step();
        idle(); step(); step();
        chk("single_count_zero", {29'd0, count}, 32'd0);

        // Fill behind a non-matching load, 5th store refused, then drain in order
        ld_valid = 1'b1; ld_addr = 32'h200; ld_size = 2'b10;
        for (int i = 0; i < 5; i++) begin
            store(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b10);
            step();
        end
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_st_ready", {31'd0, st_ready}, 32'd0);
        idle();
        repeat (5) step();

        // Byte store then overlapping word load: stall until drained
        store(32'h103, 32'h0000_00AB, 2'b00); step();
        idle(); ld_valid = 1'b1; ld_addr = 32'h100; ld_size = 2'b10; ld_signed = 1'b1;
        repeat (3) step();
        chk("hazard_load_addr", mem_addr, 32'h100);
        idle(); step();

        // Misaligned half store
        store(32'h101, 32'h1234_5678, 2'b01); step();
        idle(); step();
        chk("misaligned_count", {29'd0, count}, 32'd0);

        // Three pending, then flush with no loads
        ld_valid = 1'b1; ld_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            store(32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i), 2'b10);
            step();
        end
        idle(); flush = 1'b1;
        store(32'h80, 32'h5555_5555, 2'b10);
        repeat (3) step();
        chk("flush_drained", {31'd0, drained}, 32'd1);
        idle(); step();

        // Reset with three pending
        ld_valid = 1'b1; ld_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            store(32'h60 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'b10);
            step();
        end
        idle(); ld_valid = 1'b1; ld_addr = 32'h200; reset = 1'b1; step();
        idle(); step();
        chk("reset_count", {29'd0, count}, 32'd0);
        step();

        // Random traffic over a small address window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            st_valid  = 1'($urandom_range(0, 1));
            st_addr   = 32'h100 + 32'($urandom_range(0, 31));
            st_wdata  = $urandom;
            st_size   = 2'($urandom_range(0, 2));
            ld_valid  = ($urandom_range(0, 2) == 0);
            ld_addr   = 32'h100 + 32'($urandom_range(0, 31));
            ld_size   = 2'($urandom_range(0, 2));
            ld_signed = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
